fifo_rd_stream: RTL and testbench

- Read-side adapter placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO's rd strobe and captures rd_dat when rd_dat_vld arrives one cycle later.
- Presents the captured words as a valid/ready stream with full throughput, one word per cycle.
- Keeps a small internal skid buffer so downstream back-pressure never loses a word that was already read.

---
 rtl/fifo_rd_stream_if.sv | 21 ++
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready word stream leaving the FIFO read adapter.
// Master drives vld/dat, slave returns rdy.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 32
);
  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] dat;

  modport master (
    output vld,
    output dat,
    input  rdy
  );

  modport slave (
    input  vld,
    input  dat,
    output rdy
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: issues reads, absorbs the 1-cycle read
// latency in a small skid buffer, and presents a full-rate stream.
module fifo_rd_stream #(
  parameter int DATA_W     = 32,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rd_dat,
  input  logic              fifo_rd_dat_vld,
  input  logic              flush,
  fifo_rd_stream_if.master  out,
  output logic [CNT_W-1:0]  occ,
  output logic              err
);

  localparam int PTR_W =
    (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH =
    (CNT_W+1)'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(SKID_DEPTH - 1);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              inflight;
  logic              rst_d;

  logic              pop;
  logic              take;
  logic              push;
  logic              ovf;
  logic              stray;
  logic [CNT_W:0]    pend;
  logic [CNT_W:0]    after;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign out.vld = (occ != '0);
  assign out.dat = mem[head];

  assign pop = out.vld & out.rdy;

  // Read gate looks at this cycle's pop, so out.rdy reaches
  // fifo_rd combinationally; this keeps one word per cycle.
  assign pend = {1'b0, occ}
              + {{CNT_W{1'b0}}, inflight}
              - {{CNT_W{1'b0}}, pop};
  assign fifo_rd = ~rst & ~flush & ~fifo_empty
                 & (pend < DEPTH);

  assign take  = fifo_rd_dat_vld & inflight & ~flush;
  assign after = {1'b0, occ} + (CNT_W+1)'(1)
               - {{CNT_W{1'b0}}, pop};
  assign ovf   = after > DEPTH;
  assign push  = take & ~ovf;

  // Data valid with nothing outstanding is a protocol fault,
  // except right after reset when a pre-reset read may land.
  assign stray = fifo_rd_dat_vld & ~inflight
               & ~flush & ~rst_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      err      <= 1'b0;
      rst_d    <= 1'b1;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rst_d    <= 1'b0;
      inflight <= fifo_rd;
      if (stray | (take & ovf)) begin
        err <= 1'b1;
      end
      if (flush) begin
        occ  <= '0;
        head <= tail;
      end else begin
        if (push) begin
          mem[tail] <= fifo_rd_dat;
          tail      <= nxt(tail);
        end
        if (pop) begin
          head <= nxt(head);
        end
        occ <= occ + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based upstream FIFO and a
// queue model of the skid buffer drive per-cycle checks.
module tb_fifo_rd_stream;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_rd;
  logic [W-1:0] fifo_rd_dat;
  logic         fifo_rd_dat_vld;
  logic         flush;
  logic [1:0]   occ;
  logic         err;

  fifo_rd_stream_if #(.DATA_W(W)) s ();

  fifo_rd_stream #(
    .DATA_W    (W),
    .SKID_DEPTH(2),
    .CNT_W     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_rd        (fifo_rd),
    .fifo_rd_dat    (fifo_rd_dat),
    .fifo_rd_dat_vld(fifo_rd_dat_vld),
    .flush          (flush),
    .out            (s),
    .occ            (occ),
    .err            (err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq   [$];
  logic [W-1:0] held [$];
  logic [W-1:0] got  [$];
  logic [W-1:0] src  [$];
  bit           infl_m;
  bit           err_m;
  bit           after_m;
  bit           known;
  bit           nvld;
  logic [W-1:0] ndat;
  int           errors;
  int           checks;
  int           rd_pulses;
  int           occ_max;
  int           dropped;

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(bit rdy, bit fl, bit rs, bit inj);
    bit           pop_m;
    bit           rd_exp;
    bit           rd_seen;
    bit           vld_in;
    logic [W-1:0] dat_in;
    rst             = rs;
    flush           = fl;
    s.rdy           = rdy;
    fifo_empty      = (fq.size() == 0);
    fifo_rd_dat_vld = nvld;
    fifo_rd_dat     = ndat;
    #4;
    pop_m  = (held.size() != 0) && rdy;
    rd_exp = !rs && !fl && (fq.size() != 0)
          && (held.size() + int'(infl_m) - int'(pop_m) < 2);
    chk("fifo_rd", fifo_rd, rd_exp);
    if (known) begin
      chk("out_vld", s.vld, held.size() != 0);
      chk("occ", occ, held.size());
      chk("err", err, err_m);
      if (held.size() != 0) chk("out_dat", s.dat, held[0]);
    end
    rd_seen = fifo_rd;
    vld_in  = nvld;
    dat_in  = ndat;
    if (rd_seen) rd_pulses++;
    @(posedge clk);
    nvld = 1'b0;
    if (rd_seen && fq.size() != 0) begin
      ndat = fq.pop_front();
      nvld = 1'b1;
    end
    if (inj) begin
      ndat = 32'hDEAD_BEEF;
      nvld = 1'b1;
    end
    if (rs) begin
      held.delete();
      infl_m  = 0;
      err_m   = 0;
      after_m = 1;
      known   = 1;
    end else begin
      if (pop_m) got.push_back(held.pop_front());
      if (fl) begin
        dropped += held.size() + int'(vld_in && infl_m);
        held.delete();
      end else if (vld_in) begin
        if (infl_m) held.push_back(dat_in);
        else if (!after_m) err_m = 1;
      end
      infl_m  = rd_exp;
      after_m = 0;
    end
    if (held.size() > occ_max) occ_max = held.size();
    #1;
  endtask

  initial begin
    errors = 0; checks = 0; rd_pulses = 0;
    occ_max = 0; dropped = 0;
    nvld = 0; ndat = '0; known = 0;
    infl_m = 0; err_m = 0; after_m = 0;
    rst = 1; flush = 0; s.rdy = 0; fifo_empty = 1;
    fifo_rd_dat = '0; fifo_rd_dat_vld = 0;

    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);

    // empty FIFO: nothing read, bus idle
    rd_pulses = 0;
    repeat (4) cyc(1, 0, 0, 0);
    chk("empty_dat", s.dat, '0);
    chk("empty_vld", s.vld, 1'b0);
    chk("empty_rd", rd_pulses, 0);

    // full-rate streaming of 4 words
    got.delete(); occ_max = 0; rd_pulses = 0;
    fq = '{32'h11, 32'h22, 32'h33, 32'h44};
    src = fq;
    repeat (8) cyc(1, 0, 0, 0);
    chk("stream_cnt", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk("stream_ord", got[i], src[i]);
    chk("stream_occmax", occ_max <= 1, 1);
    chk("stream_rds", rd_pulses, 4);

    // back-pressure: 2 reads then hold
    got.delete(); rd_pulses = 0;
    fq = '{32'h101, 32'h102, 32'h103,
           32'h104, 32'h105, 32'h106};
    src = fq;
    repeat (10) cyc(0, 0, 0, 0);
    chk("stall_rds", rd_pulses, 2);
    chk("stall_occ", occ, 2);
    chk("stall_dat", s.dat, 32'h101);
    repeat (10) cyc(1, 0, 0, 0);
    chk("stall_cnt", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk("stall_ord", got[i], src[i]);

    // toggled then random ready with refills
    got.delete(); src.delete(); occ_max = 0;
    for (int i = 0; i < 24; i++) begin
      fq.push_back($urandom);
      src.push_back(fq[$]);
    end
    for (int i = 0; i < 48; i++) begin
      if (i < 16) cyc(bit'(i % 2 == 0), 0, 0, 0);
      else cyc(bit'($urandom_range(0, 1)), 0, 0, 0);
      if (i < 32 && $urandom_range(0, 3) == 0) begin
        fq.push_back($urandom);
        src.push_back(fq[$]);
      end
    end
    repeat (60) cyc(1, 0, 0, 0);
    chk("rand_cnt", got.size(), src.size());
    for (int i = 0; i < got.size() && i < src.size(); i++)
      chk("rand_ord", got[i], src[i]);
    chk("rand_occmax", occ_max <= 2, 1);

    // flush with a full skid buffer
    got.delete(); dropped = 0;
    fq = '{32'h201, 32'h202, 32'h203,
           32'h204, 32'h205, 32'h206};
    src = fq;
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("flush_occ", occ, 0);
    chk("flush_vld", s.vld, 1'b0);
    chk("flush_drop", dropped, 2);
    repeat (12) cyc(1, 0, 0, 0);
    chk("flush_cnt", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk("flush_ord", got[i], src[i + 2]);

    // flush in mid-stream
    got.delete(); dropped = 0;
    fq = '{32'h301, 32'h302, 32'h303,
           32'h304, 32'h305, 32'h306};
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (12) cyc(1, 0, 0, 0);
    chk("mflush_sum", got.size() + dropped, 6);
    for (int i = 1; i < got.size(); i++)
      chk("mflush_ord", got[i] > got[i-1], 1);

    // stray data valid sets sticky err
    cyc(1, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0);
    chk("err_set", err, 1'b1);
    chk("err_occ", occ, 0);

    // reset clears err; late valid after reset ignored
    cyc(1, 0, 1, 1);
    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_occ", occ, 0);
    chk("rst_vld", s.vld, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
